// File: rtl/rand_pkg.sv
// Shared defaults, FSM state type and a saturating-increment helper for the range picker.
package rand_pkg;

  localparam int RND_W_DEF = 13;
  localparam int OUT_W_DEF = 7;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_RUN   = 2'd1,
    S_ERR   = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/rand_range_picker_if.sv
// Sample-in / ranged-value-out bundle; master drives samples, limit and out_ready.
interface rand_range_picker_if
  import rand_pkg::*;
#(
  parameter int RND_W = RND_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  logic [RND_W-1:0] rnd_in;
  logic             rnd_valid;
  logic [OUT_W-1:0] limit;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_value;
  logic             limit_err;
  logic [7:0]       reject_count;
  logic [7:0]       drop_count;

  modport master (
    output rnd_in, rnd_valid, limit, out_ready,
    input  out_valid, out_value, limit_err, reject_count, drop_count
  );

  modport slave (
    input  rnd_in, rnd_valid, limit, out_ready,
    output out_valid, out_value, limit_err, reject_count, drop_count
  );

endinterface

// File: rtl/rand_fifo.sv
// First-word-fall-through FIFO, 1-cycle push-to-head latency; push when full is ignored
// unless a pop happens the same cycle. dout holds the last head value while empty.
module rand_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [W-1:0]  hold_q;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? hold_q : mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      hold_q <= dout;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= ptr_next(wr_ptr);
        if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/rand_range_picker.sv
// Masks LFSR samples into [0, limit-1] by rejection and queues them; head appears 1 cycle
// after an accepted sample. Full FIFO with no pop drops the sample and counts it.
module rand_range_picker
  import rand_pkg::*;
#(
  parameter int RND_W = RND_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  rand_range_picker_if.slave bus
);

  localparam int CW = $clog2(DEPTH+1);

  state_e           state_q;
  state_e           state_d;
  logic [OUT_W-1:0] limit_q;
  logic [OUT_W-1:0] lim_m1;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] cand;
  logic [7:0]       rej_q;
  logic [7:0]       drop_q;
  logic             limit_chg;
  logic             sample_ok;
  logic             accept;
  logic             reject;
  logic             push;
  logic             drop;
  logic             pop;
  logic             flush;
  logic             out_valid_w;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             unused_ok;

  assign unused_ok = ^{bus.rnd_in[RND_W-1:OUT_W], fifo_count};

  // Fill every bit at or below the MSB of limit_q-1 to get the smallest 2^k-1 cover.
  assign lim_m1 = limit_q - OUT_W'(1);
  always_comb begin
    mask = '0;
    for (int i = 0; i < OUT_W; i++) begin
      mask[i] = |(lim_m1 >> i);
    end
  end

  assign cand      = bus.rnd_in[OUT_W-1:0] & mask;
  assign limit_chg = (bus.limit != limit_q);
  assign flush     = (state_q == S_FLUSH);
  assign sample_ok = (state_q == S_RUN) && !limit_chg && bus.rnd_valid;
  assign accept    = sample_ok && (cand < limit_q);
  assign reject    = sample_ok && !accept;

  // The head is withheld during the flush cycle so nothing stale can be consumed.
  assign out_valid_w = !fifo_empty && !flush;
  assign pop         = out_valid_w && bus.out_ready;
  assign push        = accept && (!fifo_full || pop);
  assign drop        = accept && !push;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FLUSH: state_d = (bus.limit == '0) ? S_ERR : S_RUN;
      S_RUN:   if (limit_chg) state_d = S_FLUSH;
      S_ERR:   if (bus.limit != '0) state_d = S_FLUSH;
      default: state_d = S_FLUSH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FLUSH;
      limit_q <= '0;
      rej_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        limit_q <= bus.limit;
        rej_q   <= '0;
        drop_q  <= '0;
      end else begin
        if (reject) rej_q  <= sat_inc(rej_q);
        if (drop)   drop_q <= sat_inc(drop_q);
      end
    end
  end

  rand_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (cand),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid    = out_valid_w;
  assign bus.out_value    = fifo_dout;
  assign bus.limit_err    = (state_q == S_ERR);
  assign bus.reject_count = rej_q;
  assign bus.drop_count   = drop_q;

endmodule

// File: tb/tb_rand_range_picker.sv
// Directed bench for rand_range_picker: queue-based reference model checked every negedge,
// plus literal expectations at the key points of each scenario.
module tb_rand_range_picker;
  import rand_pkg::*;

  localparam int RND_W = 13;
  localparam int OUT_W = 7;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rand_range_picker_if #(.RND_W(RND_W), .OUT_W(OUT_W)) bus ();

  rand_range_picker #(.RND_W(RND_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected queue contents, phase flags and counters.
  int mq[$];
  int m_limq  = 0;
  bit m_flush = 1'b1;
  bit m_err   = 1'b0;
  int m_rej   = 0;
  int m_drop  = 0;
  int m_last  = 0;
  bit m_pop;
  int m_cand;

  function automatic int mask_of(input int n);
    int p = 1;
    while (p < n) p = p * 2;
    return p - 1;
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && !m_flush;
  endfunction

  function automatic int m_value();
    return (mq.size() > 0) ? mq[0] : m_last;
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      mq.delete();
      m_limq = 0; m_flush = 1'b1; m_err = 1'b0;
      m_rej = 0; m_drop = 0; m_last = 0;
    end else begin
      m_pop  = m_valid() && bus.out_ready;
      m_last = m_value();
      if (m_flush) begin
        mq.delete();
        m_rej = 0; m_drop = 0;
        m_limq  = int'(bus.limit);
        m_flush = 1'b0;
        m_err   = (m_limq == 0);
      end else if (m_err) begin
        if (bus.limit != 0) begin
          m_err = 1'b0; m_flush = 1'b1;
        end
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (int'(bus.limit) != m_limq) begin
          m_flush = 1'b1;
        end else if (bus.rnd_valid) begin
          m_cand = (int'(bus.rnd_in) % (1 << OUT_W)) & mask_of(m_limq);
          if (m_cand < m_limq) begin
            if (mq.size() < DEPTH) mq.push_back(m_cand);
            else if (m_drop < 255) m_drop++;
          end else if (m_rej < 255) begin
            m_rej++;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    check("mdl_valid", bus.out_valid, m_valid());
    check("mdl_value", bus.out_value, m_value());
    check("mdl_err",   bus.limit_err, m_err);
    check("mdl_rej",   bus.reject_count, m_rej);
    check("mdl_drop",  bus.drop_count, m_drop);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input logic [RND_W-1:0] v);
    bus.rnd_in    = v;
    bus.rnd_valid = 1'b1;
    tick();
  endtask

  initial begin
    bus.rnd_in    = '0;
    bus.rnd_valid = 1'b0;
    bus.limit     = 7'd10;
    bus.out_ready = 1'b1;

    // Reset values
    #12;
    check("rst_valid", bus.out_valid, 0);
    check("rst_value", bus.out_value, 0);
    check("rst_err",   bus.limit_err, 0);
    check("rst_rej",   bus.reject_count, 0);
    check("rst_drop",  bus.drop_count, 0);
    reset = 1'b0;
    tick();
    check("post_flush_valid", bus.out_valid, 0);

    // First sample with limit 10
    sample(13'h0005);
    bus.rnd_valid = 1'b0;
    check("first_valid", bus.out_valid, 1);
    check("first_value", bus.out_value, 5);

    // 13 masked by 15 is out of range
    sample(13'h1F0D);
    bus.rnd_valid = 1'b0;
    check("rej_count1", bus.reject_count, 1);
    check("rej_valid0", bus.out_valid, 0);
    check("rej_hold",   bus.out_value, 5);

    // Backpressure: five samples into four entries
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) sample(RND_W'(i));
    bus.rnd_valid = 1'b0;
    check("bp_drop", bus.drop_count, 1);
    check("bp_head", bus.out_value, 1);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_order", bus.out_value, i);
      tick();
    end
    check("bp_empty", bus.out_valid, 0);
    check("bp_last",  bus.out_value, 4);

    // Limit change 10 -> 6 with three entries queued
    bus.out_ready = 1'b0;
    sample(13'd7); sample(13'd8); sample(13'd9);
    bus.limit = 7'd6;
    sample(13'd2);
    bus.rnd_valid = 1'b0;
    check("chg_flush_valid", bus.out_valid, 0);
    tick();
    check("chg_rej0",  bus.reject_count, 0);
    check("chg_drop0", bus.drop_count, 0);
    check("chg_empty", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    sample(13'h0003);
    bus.rnd_valid = 1'b0;
    check("chg_value", bus.out_value, 3);
    check("chg_vld",   bus.out_valid, 1);

    // Reject counter saturation (15 & 7 = 7 >= 6)
    for (int i = 0; i < 260; i++) sample(13'h000F);
    check("rej_sat", bus.reject_count, 255);
    // Drop counter saturation
    bus.out_ready = 1'b0;
    for (int i = 0; i < 262; i++) sample(13'h0001);
    check("drop_sat", bus.drop_count, 255);

    // limit 0 -> error state, no output
    bus.limit = 7'd0;
    sample(13'h0002);
    tick();
    check("err_set",   bus.limit_err, 1);
    check("err_noval", bus.out_valid, 0);
    for (int i = 0; i < 3; i++) sample(RND_W'(i * 37));
    check("err_still_noval", bus.out_valid, 0);
    check("err_rej0",        bus.reject_count, 0);

    // limit 1: every sample maps to 0, no rejections
    bus.limit = 7'd1;
    tick();
    check("err_clear", bus.limit_err, 0);
    tick();
    bus.out_ready = 1'b1;
    sample(13'h1FFF);
    check("one_value", bus.out_value, 0);
    check("one_valid", bus.out_valid, 1);
    sample(13'h0AAA); sample(13'h0055); sample(13'h007F); sample(13'h1234);
    bus.rnd_valid = 1'b0;
    check("one_rej0", bus.reject_count, 0);
    check("one_drop0", bus.drop_count, 0);

    // Mid-cycle reset with a full FIFO
    bus.limit = 7'd10;
    tick(); tick();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) sample(RND_W'(i + 2));
    bus.rnd_valid = 1'b0;
    check("pre_rst_valid", bus.out_valid, 1);
    check("pre_rst_drop",  bus.drop_count, 1);
    #3 reset = 1'b1;
    #1;
    check("async_valid", bus.out_valid, 0);
    check("async_value", bus.out_value, 0);
    check("async_err",   bus.limit_err, 0);
    check("async_rej",   bus.reject_count, 0);
    check("async_drop",  bus.drop_count, 0);
    tick(); tick();
    #2;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    bus.rnd_in    = 13'd4;
    bus.rnd_valid = 1'b1;
    tick();
    check("rst_edge1_nopush", bus.out_valid, 0);
    tick();
    bus.rnd_valid = 1'b0;
    check("rst_edge2_valid", bus.out_valid, 1);
    check("rst_edge2_value", bus.out_value, 4);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_range_picker.md
RAND_RANGE_PICKER -- requirements
Module: rand_range_picker

Interface
REQ-001 SHALL have parameter RND_W, default 13, width of the incoming LFSR word.
REQ-002 SHALL have parameter OUT_W, default 7, width of the ranged output value.
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO depth in entries.
REQ-004 SHALL have port clock  input  1  rising-edge system clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rnd_in  input  RND_W  raw pseudo-random word from the LFSR stage.
REQ-007 SHALL have port rnd_valid  input  1  rnd_in is a fresh sample this cycle.
REQ-008 SHALL have port limit  input  OUT_W  exclusive upper bound N; outputs lie in [0, N-1].
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_value this cycle.
REQ-010 SHALL have port out_valid  output  1  out_value holds an unconsumed ranged value.
REQ-011 SHALL have port out_value  output  OUT_W  head-of-FIFO ranged value.
REQ-012 SHALL have port limit_err  output  1  limit is 0; no values are produced.
REQ-013 SHALL have port reject_count  output  8  saturating count of out-of-range rejections.
REQ-014 SHALL have port drop_count  output  8  saturating count of in-range samples lost to a full FIFO.

Function
REQ-015 SHALL use an FSM with states S_FLUSH, S_RUN, S_ERR.
REQ-016 S_FLUSH SHALL last exactly one cycle: empty the FIFO, clear both counters, capture limit into limit_q, then go to S_ERR if limit==0, else S_RUN.
REQ-017 In S_RUN, if limit != limit_q, the next state SHALL be S_FLUSH, and that cycle's sample SHALL be discarded without being counted.
REQ-018 In S_ERR, limit_err SHALL be 1 and no push SHALL occur; when limit becomes nonzero, the next state SHALL be S_FLUSH.
REQ-019 mask SHALL be the smallest (2^k)-1 that is >= limit_q-1 (limit_q=1 gives mask 0; limit_q=10 gives 15; limit_q=100 gives 127).
REQ-020 candidate SHALL equal rnd_in[OUT_W-1:0] AND mask; higher rnd_in bits are ignored.
REQ-021 In S_RUN with rnd_valid=1, a candidate < limit_q SHALL be accepted; otherwise reject_count SHALL increment.
REQ-022 An accepted candidate SHALL be pushed if the FIFO is not full, or if a pop occurs in the same cycle; otherwise drop_count SHALL increment.
REQ-023 A pop SHALL occur when out_valid and out_ready are both 1.
REQ-024 The FIFO SHALL be first-word-fall-through: a value pushed at edge t SHALL appear on out_value with out_valid=1 after edge t, i.e. 1-cycle latency.
REQ-025 When the FIFO is empty, out_valid SHALL be 0 and out_value SHALL hold its last value.
REQ-026 Counters SHALL saturate at 255 and never wrap.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a separate count of 0..DEPTH.

Reset
REQ-028 Assertion of reset SHALL immediately force: state S_FLUSH, out_valid 0, out_value 0, limit_err 0, reject_count 0, drop_count 0, FIFO empty, limit_q 0.
REQ-029 Assertion of reset mid-operation SHALL discard all FIFO contents; the first push SHALL occur no earlier than the second edge after deassertion.

Structure
REQ-030 Package rand_pkg SHALL hold the RND_W, OUT_W and DEPTH defaults and the state enum type.
REQ-031 The FIFO SHALL be the sub-module rand_fifo: synchronous, first-word-fall-through, with push, pop, flush, full, empty and count signals.
REQ-032 Mask generation and the accept compare SHALL be combinational within rand_range_picker.

Verification
REQ-033 Reset, limit=10, out_ready=1, rnd_in=13'h0005 valid -> after S_FLUSH, out_value=5 and out_valid=1 one cycle after the sample.
REQ-034 limit=10, rnd_in=13'h1F0D valid -> candidate 13 rejected, reject_count=1, out_valid stays 0.
REQ-035 limit=10, out_ready=0, five valid samples 1,2,3,4,5 -> FIFO holds 1..4, drop_count=1; raising out_ready yields 1,2,3,4 in order.
REQ-036 FIFO holding 3 entries, limit changes 10->6 -> next cycle S_FLUSH, out_valid=0, counters=0; the next sample 13'h0003 gives out_value=3.
REQ-037 limit=0 -> limit_err=1 with no outputs; limit=1 with arbitrary samples -> every output is 0 and there are no rejections.
REQ-038 Reset asserted mid-cycle while the FIFO is full -> outputs take reset values before the next clock edge.
